sum_rx_fifo: RTL

Receive side of the inter-core softmax-sum link. It accepts 24-bit partial sums that the peer core drives out with a valid strobe. It buffers them in a small FIFO and hands them to the local core's SFP row one entry per `fifo_ext_rd` pop, returning `sum_rd_vld` alongside the data. It sits between the peer core's `sum_out`/`sum_out_vld` pair and the local core's `sum_in`/`fifo_ext_rd`/`sum_rd_vld` pins.

---
 rtl/sum_rx_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/sum_rx_fifo.sv
// rtl/sum_rx_fifo.sv - receive FIFO for the inter-core softmax-sum link
// Optional feature macro: SUM_RX_BYPASS_EN (empty-FIFO write+pop cut-through)
module sum_rx_fifo #(
  parameter int bw_psum = 20,
  parameter int depth   = 4,
  parameter int aw      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bw_psum+3:0]   peer_sum,
  input  logic                 peer_sum_vld,
  input  logic                 fifo_ext_rd,
  output logic [bw_psum+3:0]   sum_in,
  output logic                 sum_rd_vld,
  output logic                 empty,
  output logic                 full,
  output logic [aw:0]          count,
  output logic                 ovf,
  output logic                 udf
);

  localparam int            dw        = bw_psum + 4;
  localparam logic [aw:0]   depth_cnt = (aw+1)'(depth);

  logic [dw-1:0] mem [0:depth-1];
  logic [aw-1:0] wp;
  logic [aw-1:0] rp;

  logic rd_ok;
  logic wr_ok;
  logic bypass;
  logic ovf_set;
  logic udf_set;

  // Occupancy flags come straight from the registered count.
  assign empty = (count == '0);
  assign full  = (count == depth_cnt);

  // Accept/reject decisions for the current cycle's write and pop.
  always_comb begin
    bypass  = 1'b0;
`ifdef SUM_RX_BYPASS_EN
    // Cut-through: the word goes straight to sum_in and is never stored.
    bypass  = empty && peer_sum_vld && fifo_ext_rd;
`endif
    rd_ok   = fifo_ext_rd && !empty;
    // A pop in the same cycle frees a slot, so a write at full still fits.
    wr_ok   = peer_sum_vld && (!full || rd_ok) && !bypass;
    ovf_set = peer_sum_vld && full && !rd_ok;
    udf_set = fifo_ext_rd && empty && !bypass;
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= peer_sum;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= rp + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (udf_set) begin
        udf <= 1'b1;
      end
    end
  end

  // Registered read port: sum_in holds between pops, sum_rd_vld pulses once per pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_in     <= '0;
      sum_rd_vld <= 1'b0;
    end else begin
      sum_rd_vld <= rd_ok || bypass;
      if (rd_ok) begin
        sum_in <= mem[rp];
      end else if (bypass) begin
        sum_in <= peer_sum;
      end
    end
  end

endmodule
